// File: rtl/rf_wb_sched_pkg.sv
// rf_wb_sched_pkg: shared types for the register-file write-back scheduler.
package rf_wb_sched_pkg;
  localparam int REG_NUM = 32;
  localparam int XLEN = 64;
  localparam int WB_REQ_NUM = 2;
  localparam int SB_CNT_W = 2;
  typedef logic [$clog2(REG_NUM)-1:0] reg_ind_t;
  typedef logic [XLEN-1:0] data_t;
  typedef logic [SB_CNT_W-1:0] sb_cnt_t;
  typedef struct packed {
    logic     valid;
    reg_ind_t rd;
    data_t    data;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_sched_wb_rr_arbiter.sv
// wb_rr_arbiter: 2-way round-robin grant; the pointer flips to the loser after each conflict.
module wb_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic ptr_q, ptr_d;
  always_comb begin
    grant = (valid == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : valid;
    ptr_d = (valid == 2'b11) ? ~ptr_q : ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: write-back arbiter, commit stage and per-register pending-write scoreboard.
// Define RF_WB_BYPASS_EN to add commit-cycle forwarding outputs (rs1_fwd, rs2_fwd, fwd_data).
module rf_wb_sched import rf_wb_sched_pkg::*; #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  reg_ind_t   issue_rd,
  output logic       issue_ready,
  input  reg_ind_t   rs1_addr,
  input  reg_ind_t   rs2_addr,
  output logic       rs1_busy,
  output logic       rs2_busy,
  input  logic [1:0] wb_valid,
  input  reg_ind_t   wb_rd [WB_REQ_NUM],
  input  data_t      wb_data [WB_REQ_NUM],
  output logic [1:0] wb_ready,
  output logic       rf_we,
  output reg_ind_t   rf_waddr,
  output data_t      rf_wdata,
  output logic       sb_err
`ifdef RF_WB_BYPASS_EN
  ,
  output logic       rs1_fwd,
  output logic       rs2_fwd,
  output data_t      fwd_data
`endif
);
  logic [CNT_W-1:0] cnt_q [REG_NUM];
  logic [CNT_W-1:0] cnt_d [REG_NUM];
  logic rf_we_q, rf_we_d, sb_err_q, sb_err_d;
  reg_ind_t rf_waddr_q, rf_waddr_d;
  data_t rf_wdata_q, rf_wdata_d;
  logic [1:0] grant;
  wb_req_t req [WB_REQ_NUM];
  wb_req_t win;
  logic issue_acc, fwd1, fwd2;
  wb_rr_arbiter u_arb (.clk(clk), .rst(rst), .valid(wb_valid), .grant(grant));
  always_comb begin
    for (int i = 0; i < WB_REQ_NUM; i++) req[i] = '{valid: wb_valid[i], rd: wb_rd[i], data: wb_data[i]};
    win = grant[1] ? req[1] : req[0];
    wb_ready = grant;
    rf_we_d = |grant && win.rd != '0;
    rf_waddr_d = |grant ? win.rd : rf_waddr_q;
    rf_wdata_d = |grant ? win.data : rf_wdata_q;
    issue_ready = issue_rd == '0 || cnt_q[issue_rd] != '1 || (rf_we_q && rf_waddr_q == issue_rd);
    issue_acc = issue_valid && issue_ready && issue_rd != '0;
    fwd1 = rf_we_q && rf_waddr_q == rs1_addr && rs1_addr != '0 && cnt_q[rs1_addr] == CNT_W'(1);
    fwd2 = rf_we_q && rf_waddr_q == rs2_addr && rs2_addr != '0 && cnt_q[rs2_addr] == CNT_W'(1);
    sb_err_d = sb_err_q | (rf_we_q && cnt_q[rf_waddr_q] == '0);
    cnt_d = cnt_q;
    // Simultaneous issue and commit to one register cancel; decrement saturates at zero.
    for (int i = 1; i < REG_NUM; i++) begin
      if (rf_we_q && rf_waddr_q == reg_ind_t'(i) && !(issue_acc && issue_rd == reg_ind_t'(i)))
        cnt_d[i] = (cnt_q[i] == '0) ? '0 : cnt_q[i] - 1'b1;
      else if (issue_acc && issue_rd == reg_ind_t'(i) && !(rf_we_q && rf_waddr_q == reg_ind_t'(i)))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '{default: '0};
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      sb_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rf_we_q <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      sb_err_q <= sb_err_d;
    end
  end
  assign rf_we = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign sb_err = sb_err_q;
`ifdef RF_WB_BYPASS_EN
  assign rs1_fwd = fwd1;
  assign rs2_fwd = fwd2;
  assign fwd_data = rf_wdata_q;
  assign rs1_busy = rs1_addr != '0 && cnt_q[rs1_addr] != '0 && !fwd1;
  assign rs2_busy = rs2_addr != '0 && cnt_q[rs2_addr] != '0 && !fwd2;
`else
  assign rs1_busy = rs1_addr != '0 && cnt_q[rs1_addr] != '0 && (fwd1 | 1'b1);
  assign rs2_busy = rs2_addr != '0 && cnt_q[rs2_addr] != '0 && (fwd2 | 1'b1);
`endif
endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: directed vectors for rf_wb_sched with hand-computed expectations.
module tb_rf_wb_sched;
  import rf_wb_sched_pkg::*;
  logic clk = 0, rst = 1;
  logic issue_valid = 0, issue_ready;
  reg_ind_t issue_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic rs1_busy, rs2_busy;
  logic [1:0] wb_valid = '0, wb_ready;
  reg_ind_t wb_rd [2];
  data_t wb_data [2];
  logic rf_we, sb_err;
  reg_ind_t rf_waddr;
  data_t rf_wdata;
  int vectors = 0, miscompares = 0;
`ifdef RF_WB_BYPASS_EN
  logic rs1_fwd, rs2_fwd;
  data_t fwd_data;
`endif
  rf_wb_sched dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sb_err(sb_err)
`ifdef RF_WB_BYPASS_EN
    , .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input reg_ind_t rd);
    issue_valid = 1; issue_rd = rd;
    tick();
    issue_valid = 0;
  endtask
  task automatic wb(input int idx, input reg_ind_t rd, input data_t d);
    wb_valid = 2'b01 << idx; wb_rd[idx] = rd; wb_data[idx] = d;
    #1 chk("wb_ready", wb_ready, 2'b01 << idx);
    tick();
    wb_valid = 0;
  endtask
  initial begin
    wb_rd = '{default: '0};
    wb_data = '{default: '0};
    tick();
    rst = 0;
    tick();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_sb_err", sb_err, 0);
    // Issue then write-back
    issue(5);
    rs1_addr = 5;
    #1 chk("busy_after_issue", rs1_busy, 1);
    wb(0, 5, 64'hDEAD_BEEF);
    chk("commit_we", rf_we, 1);
    chk("commit_addr", rf_waddr, 5);
    chk("commit_data", rf_wdata, 64'hDEAD_BEEF);
`ifdef RF_WB_BYPASS_EN
    chk("fwd_commit_busy", rs1_busy, 0);
    chk("fwd_commit_fwd", rs1_fwd, 1);
`else
    chk("busy_held_commit", rs1_busy, 1);
`endif
    tick();
    chk("busy_cleared", rs1_busy, 0);
    chk("we_idle", rf_we, 0);
    // Conflict: two pending writes on each of r3 and r7
    issue(3); issue(3); issue(7); issue(7);
    wb_valid = 2'b11; wb_rd[0] = 3; wb_rd[1] = 7; wb_data[0] = 64'h33; wb_data[1] = 64'h77;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_grant", wb_ready, (k % 2) ? 2'b10 : 2'b01);
      tick();
      chk("rr_commit_addr", rf_waddr, (k % 2) ? 7 : 3);
      chk("rr_commit_data", rf_wdata, (k % 2) ? 64'h77 : 64'h33);
    end
    wb_valid = 0;
    tick();
    chk("rr_no_err", sb_err, 0);
    // Saturation at 3 pending writes
    issue(9); issue(9); issue(9);
    issue_rd = 9;
    #1 chk("sat_not_ready", issue_ready, 0);
    wb(0, 9, 64'h99);
    chk("sat_ready_on_commit", issue_ready, 1);
    issue(9);
    issue_rd = 9;
    #1 chk("sat_cnt_stays", issue_ready, 0);
    // Zero register and scoreboard error
    wb(1, 0, 64'h1);
    chk("r0_no_we", rf_we, 0);
    wb(1, 12, 64'hC);
    chk("err_we", rf_we, 1);
    chk("err_addr", rf_waddr, 12);
    tick();
    chk("err_set", sb_err, 1);
    tick(); tick();
    chk("err_sticky", sb_err, 1);
    // Reset mid-stream with pending writes on r5
    issue(5); issue(5);
    rs1_addr = 5;
    #1 chk("pre_rst_busy", rs1_busy, 1);
    rst = 1;
    #1 chk("arst_we", rf_we, 0);
    chk("arst_err", sb_err, 0);
    chk("arst_busy", rs1_busy, 0);
    for (int r = 0; r < 32; r++) begin
      issue_rd = reg_ind_t'(r);
      #1 chk("arst_ready", issue_ready, 1);
    end
    tick();
    rst = 0;
    tick();
`ifdef RF_WB_BYPASS_EN
    issue(4);
    rs2_addr = 4;
    wb(0, 4, 64'h55);
    chk("byp_fwd", rs2_fwd, 1);
    chk("byp_busy", rs2_busy, 0);
    chk("byp_data", fwd_data, 64'h55);
    tick();
    issue(4); issue(4);
    wb(0, 4, 64'h56);
    chk("byp_cnt2_fwd", rs2_fwd, 0);
    chk("byp_cnt2_busy", rs2_busy, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
